// File: rtl/or_accum_pkg.sv
// or_accum_pkg: shared state type, status-counter constants and count-width helper
// Ports: none (package). Imported by or_accumulator and window_counter.
package or_accum_pkg;
  typedef enum logic {ACCUM, HOLD} state_e;
  localparam int HIT_COUNT_W = 8;
  localparam int HIT_COUNT_MAX = 255;
  function automatic int cnt_w(input int window);
    return window > 1 ? $clog2(window) : 1;
  endfunction
endpackage

// File: rtl/or_accumulator_if.sv
// or_accumulator_if: sample/result valid-ready bus plus synchronous clear
// Signals: clear, in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream);
// with OR_ACCUM_STATUS_EN also hit and hit_count. master = driver side, slave = or_accumulator.
interface or_accumulator_if #(parameter int BIT_LEN = 1);
  logic clear;
  logic in_valid;
  logic in_ready;
  logic [BIT_LEN-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [BIT_LEN-1:0] out_data;
`ifdef OR_ACCUM_STATUS_EN
  logic hit;
  logic [or_accum_pkg::HIT_COUNT_W-1:0] hit_count;
  modport master(output clear, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, hit, hit_count);
  modport slave(input clear, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, hit, hit_count);
`else
  modport master(output clear, in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input clear, in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/or_accumulator_window_counter.sv
// window_counter: modulo-WINDOW sample counter with synchronous clear
// Ports: clk, rst_n (async active-low), clr_i (priority clear), inc_i (count one), last_o (count == WINDOW-1).
module window_counter import or_accum_pkg::*; #(parameter int WINDOW = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);
  localparam int CW = cnt_w(WINDOW);
  logic [CW-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == CW'(WINDOW - 1);
  always_comb cnt_d = clr_i ? '0 : inc_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/or_gate.sv
// or_gate: library bitwise OR of two BIT_LEN-wide vectors
// Ports: a_i, b_i operands; y_o = a_i | b_i.
module or_gate #(parameter int BIT_LEN = 1) (
  input  logic [BIT_LEN-1:0] a_i,
  input  logic [BIT_LEN-1:0] b_i,
  output logic [BIT_LEN-1:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/or_accumulator.sv
// or_accumulator: ORs WINDOW accepted samples into one result, presented over valid/ready
// Ports: clk, rst_n (async active-low), bus (or_accumulator_if.slave).
// Optional macro OR_ACCUM_STATUS_EN adds bus.hit (result nonzero) and bus.hit_count (saturating).
module or_accumulator import or_accum_pkg::*; #(
  parameter int BIT_LEN = 1,
  parameter int WINDOW = 4
) (
  input logic clk,
  input logic rst_n,
  or_accumulator_if.slave bus
);
  state_e state_q, state_d;
  logic [BIT_LEN-1:0] acc_q, acc_d, comb, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, accept, last, done, drain;
  assign bus.in_ready = state_q == ACCUM;
  assign accept = bus.in_valid & bus.in_ready;
  // clear discards a window completing in the same cycle
  assign done = accept & last & ~bus.clear;
  assign drain = (state_q == HOLD) & bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  or_gate #(.BIT_LEN(BIT_LEN)) u_or (.a_i(acc_q), .b_i(bus.in_data), .y_o(comb));
  window_counter #(.WINDOW(WINDOW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.clear), .inc_i(accept), .last_o(last)
  );
  always_comb begin
    state_d = bus.clear ? ACCUM : done ? HOLD : drain ? ACCUM : state_q;
    acc_d = bus.clear ? '0 : accept ? comb : drain ? '0 : acc_q;
    out_valid_d = bus.clear ? 1'b0 : done ? 1'b1 : drain ? 1'b0 : out_valid_q;
    out_data_d = done ? comb : out_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
`ifdef OR_ACCUM_STATUS_EN
  logic hit_q, hit_d;
  logic [HIT_COUNT_W-1:0] hit_cnt_q, hit_cnt_d;
  assign bus.hit = hit_q;
  assign bus.hit_count = hit_cnt_q;
  always_comb begin
    hit_d = bus.clear ? 1'b0 : done ? |comb : hit_q;
    hit_cnt_d = (done && |comb && hit_cnt_q != HIT_COUNT_W'(HIT_COUNT_MAX)) ? hit_cnt_q + 1'b1 : hit_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      hit_q <= hit_d;
      hit_cnt_q <= hit_cnt_d;
    end
`endif
endmodule

// File: tb/tb_or_accumulator.sv
// tb_or_accumulator: scoreboard bench for or_accumulator with lanes WINDOW=3 and WINDOW=1
module tb_or_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear[2], in_valid[2], out_ready[2], in_ready[2], out_valid[2];
  logic [3:0] in_data[2], out_data[2];
`ifdef OR_ACCUM_STATUS_EN
  logic hit[2];
  logic [7:0] hit_count[2];
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask
  task automatic cyc(input int l, input logic v, input logic [3:0] d, input logic r, input logic c);
    in_valid[l] = v;
    in_data[l] = d;
    out_ready[l] = r;
    clear[l] = c;
    @(posedge clk);
    #1;
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = g == 0 ? 3 : 1;
    or_accumulator_if #(.BIT_LEN(4)) bus();
    assign bus.clear = clear[g];
    assign bus.in_valid = in_valid[g];
    assign bus.in_data = in_data[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g] = bus.in_ready;
    assign out_valid[g] = bus.out_valid;
    assign out_data[g] = bus.out_data;
`ifdef OR_ACCUM_STATUS_EN
    assign hit[g] = bus.hit;
    assign hit_count[g] = bus.hit_count;
`endif
    or_accumulator #(.BIT_LEN(4), .WINDOW(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [3:0] win_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] r;
    bit m_hold = 0;
    bit m_hit = 0;
    int m_hc = 0;
    // reference model: collect accepted samples, OR them once W are in hand
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        win_q.delete();
        exp_q.delete();
        m_hold = 0;
        m_hit = 0;
        m_hc = 0;
      end else if (clear[g]) begin
        win_q.delete();
        exp_q.delete();
        m_hold = 0;
        m_hit = 0;
      end else if (m_hold) begin
        m_hold = !out_ready[g];
      end else if (in_valid[g]) begin
        win_q.push_back(in_data[g]);
        if (win_q.size() == W) begin
          r = 4'b0;
          foreach (win_q[i]) r = r | win_q[i];
          exp_q.push_back(r);
          win_q.delete();
          m_hold = 1;
          m_hit = r != 4'b0;
          if (r != 4'b0 && m_hc < 255) m_hc++;
        end
      end
    end
    // monitor: compare presented result against the scoreboard head
    initial forever begin
      @(negedge clk);
      chk($sformatf("lane%0d out_valid", g), 8'(out_valid[g]), 8'(m_hold));
      chk($sformatf("lane%0d in_ready", g), 8'(in_ready[g]), 8'(!m_hold));
      if (out_valid[g] && exp_q.size() != 0) begin
        chk($sformatf("lane%0d out_data", g), 8'(out_data[g]), 8'(exp_q[0]));
        if (out_ready[g] && !clear[g]) void'(exp_q.pop_front());
      end
`ifdef OR_ACCUM_STATUS_EN
      chk($sformatf("lane%0d hit", g), 8'(hit[g]), 8'(m_hit));
      chk($sformatf("lane%0d hit_count", g), hit_count[g], 8'(m_hc));
`endif
    end
  end
  initial begin
    for (int l = 0; l < 2; l++) begin
      clear[l] = 1'b0;
      in_valid[l] = 1'b0;
      in_data[l] = 4'b0;
      out_ready[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset in_ready", 8'(in_ready[0]), 8'd1);
    chk("reset out_valid", 8'(out_valid[0]), 8'd0);
    cyc(0, 1, 4'b0001, 1, 0);
    cyc(0, 1, 4'b0100, 1, 0);
    cyc(0, 1, 4'b0000, 1, 0);
    chk("basic out_valid", 8'(out_valid[0]), 8'd1);
    chk("basic out_data", 8'(out_data[0]), 8'h5);
    chk("basic in_ready low", 8'(in_ready[0]), 8'd0);
    cyc(0, 0, 4'b0000, 1, 0);
    chk("basic in_ready back", 8'(in_ready[0]), 8'd1);
    cyc(0, 1, 4'b0001, 0, 0);
    cyc(0, 1, 4'b0100, 0, 0);
    cyc(0, 1, 4'b0000, 0, 0);
    repeat (5) begin
      cyc(0, 1, 4'b1000, 0, 0);
      chk("bp out_valid", 8'(out_valid[0]), 8'd1);
      chk("bp out_data", 8'(out_data[0]), 8'h5);
      chk("bp in_ready", 8'(in_ready[0]), 8'd0);
    end
    cyc(0, 0, 4'b0000, 1, 0);
    chk("bp release in_ready", 8'(in_ready[0]), 8'd1);
    cyc(0, 1, 4'b1000, 1, 0);
    cyc(0, 1, 4'b0010, 1, 0);
    cyc(0, 0, 4'b0000, 1, 1);
    repeat (3) cyc(0, 1, 4'b0001, 0, 0);
    chk("abort out_data", 8'(out_data[0]), 8'h1);
    cyc(0, 0, 4'b0000, 1, 0);
    cyc(0, 1, 4'b1000, 0, 0);
    cyc(0, 1, 4'b0010, 0, 0);
    cyc(0, 1, 4'b0000, 0, 0);
    in_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 8'(out_valid[0]), 8'd0);
    chk("async rst in_ready", 8'(in_ready[0]), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cyc(0, 1, 4'b0001, 1, 0);
    chk("post rst out_data", 8'(out_data[0]), 8'h1);
    cyc(0, 0, 4'b0000, 1, 0);
    cyc(1, 1, 4'b1010, 1, 0);
    chk("w1 first", 8'(out_data[1]), 8'hA);
    cyc(1, 1, 4'b0101, 1, 0);
    chk("w1 gap out_valid", 8'(out_valid[1]), 8'd0);
    cyc(1, 1, 4'b0101, 1, 0);
    chk("w1 second", 8'(out_data[1]), 8'h5);
    cyc(1, 0, 4'b0000, 1, 0);
    repeat (400) begin
      for (int l = 0; l < 2; l++) begin
        in_valid[l] = $urandom_range(0, 9) < 7;
        in_data[l] = 4'($urandom);
        out_ready[l] = $urandom_range(0, 9) < 6;
        clear[l] = $urandom_range(0, 31) == 0;
      end
      @(posedge clk);
      #1;
    end
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0;
      out_ready[l] = 1'b1;
      clear[l] = 1'b1;
    end
    @(posedge clk);
    #1;
    clear[0] = 1'b0;
    clear[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef OR_ACCUM_STATUS_EN
    repeat (300) begin
      cyc(0, 1, 4'($urandom_range(1, 15)), 1, 0);
      cyc(0, 1, 4'($urandom), 1, 0);
      cyc(0, 1, 4'($urandom), 1, 0);
      cyc(0, 0, 4'b0000, 1, 0);
    end
    chk("hit_count saturated", hit_count[0], 8'd255);
    repeat (3) cyc(0, 1, 4'b0000, 0, 0);
    chk("zero window hit", 8'(hit[0]), 8'd0);
    cyc(0, 0, 4'b0000, 1, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
